f_pim_checker: RTL and testbench

- Clocked, self-checking response checker for the gate-level function F(A,B,C,D) = ΠM(0,1,2,8,10,12,14).
- Sits at the DUT-output end of the exhaustive-vector flow: a stimulus source presents ABCD vectors, and the function block returns F. This block consumes each vector/result pair, compares F against the golden truth table, and tracks input-space coverage.
- After 16 accepted pairs it reports a registered pass/fail verdict. It can be used in the bench or synthesised for on-board self-test.

---
 rtl/f_pim_checker.sv | 159 +++++++++++++++
 tb/tb_f_pim_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f_pim_checker.sv
// Response checker for F(A,B,C,D) = PI M(0,1,2,8,10,12,14): compares 16 vector/result pairs against EXP_MASK and tracks coverage.
// Latency: zero-latency accept in RUN; counters/cov visible the cycle after accept; done/pass rise the cycle after the 16th accept.
// Backpressure: in_ready is a registered state decode (high only in RUN); optional FCHK_FIRST_FAIL_EN adds first-mismatch capture.
module f_pim_checker #(
    parameter logic [15:0] EXP_MASK = 16'hAAF8,
    parameter int          NVEC     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_abcd,
    input  logic        in_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [4:0]  vec_count,
`ifdef FCHK_FIRST_FAIL_EN
    output logic        first_fail_valid,
    output logic [3:0]  first_fail_abcd,
`endif
    output logic [15:0] cov
);

    localparam logic [4:0]  NVEC_C   = 5'(NVEC);
    localparam logic [15:0] COV_FULL = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_count_q, err_count_d;
    logic [4:0]  vec_count_q, vec_count_d;
    logic [15:0] cov_q, cov_d;
`ifdef FCHK_FIRST_FAIL_EN
    logic        ff_valid_q, ff_valid_d;
    logic [3:0]  ff_abcd_q, ff_abcd_d;
`endif

    logic accept;
    logic mismatch;

    // A pair is taken only when the registered ready is high, so start in DONE can never coincide with an accept.
    assign accept   = in_valid & in_ready_q;
    assign mismatch = (in_f != EXP_MASK[in_abcd]);

    // Next-state, counter, coverage and verdict computation.
    always_comb begin
        state_d     = state_q;
        err_count_d = err_count_q;
        vec_count_d = vec_count_q;
        cov_d       = cov_q;
        pass_d      = pass_q;
`ifdef FCHK_FIRST_FAIL_EN
        ff_valid_d  = ff_valid_q;
        ff_abcd_d   = ff_abcd_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // in_valid is ignored here; only start matters.
                if (start) begin
                    state_d     = S_RUN;
                    err_count_d = 5'd0;
                    vec_count_d = 5'd0;
                    cov_d       = 16'd0;
                    pass_d      = 1'b0;
`ifdef FCHK_FIRST_FAIL_EN
                    ff_valid_d  = 1'b0;
                    ff_abcd_d   = 4'd0;
`endif
                end
            end
            S_RUN: begin
                // start is ignored while a run is in progress.
                if (accept) begin
                    vec_count_d = vec_count_q + 5'd1;
                    cov_d       = cov_q | (16'd1 << in_abcd);
                    if (mismatch) begin
                        err_count_d = err_count_q + 5'd1;
                    end
`ifdef FCHK_FIRST_FAIL_EN
                    // Keep only the first mismatch of the run.
                    if (mismatch && !ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_abcd_d  = in_abcd;
                    end
`endif
                    if (vec_count_d == NVEC_C) begin
                        state_d = S_DONE;
                        pass_d  = (err_count_d == 5'd0) && (cov_d == COV_FULL);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered decodes of the next state, so they track state_q with no logic after the flop.
    always_comb begin
        in_ready_d = (state_d == S_RUN);
        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 5'd0;
            vec_count_q <= 5'd0;
            cov_q       <= 16'd0;
`ifdef FCHK_FIRST_FAIL_EN
            ff_valid_q  <= 1'b0;
            ff_abcd_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            vec_count_q <= vec_count_d;
            cov_q       <= cov_d;
`ifdef FCHK_FIRST_FAIL_EN
            ff_valid_q  <= ff_valid_d;
            ff_abcd_q   <= ff_abcd_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign vec_count = vec_count_q;
    assign cov       = cov_q;
`ifdef FCHK_FIRST_FAIL_EN
    assign first_fail_valid = ff_valid_q;
    assign first_fail_abcd  = ff_abcd_q;
`endif

endmodule

// File: tb/tb_f_pim_checker.sv
// Directed bench for f_pim_checker: drives runs of 16 pairs and compares the verdict against a queued expectation.
// Expected truth table is rebuilt here from the minterm list of F.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_f_pim_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_abcd;
    logic        in_f;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [4:0]  vec_count;
    logic [15:0] cov;
`ifdef FCHK_FIRST_FAIL_EN
    logic        first_fail_valid;
    logic [3:0]  first_fail_abcd;
`endif

    f_pim_checker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_abcd   (in_abcd),
        .in_f      (in_f),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count),
`ifdef FCHK_FIRST_FAIL_EN
        .first_fail_valid (first_fail_valid),
        .first_fail_abcd  (first_fail_abcd),
`endif
        .cov       (cov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  err;
        logic [15:0] cov;
        logic        pass;
        logic        ffv;
        logic [3:0]  ffa;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] gold;
    logic [3:0]  va [16];
    logic        fa [16];
    int          minterms [9] = '{3, 4, 5, 6, 7, 9, 11, 13, 15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the 16 pairs in va/fa; with gap=1 a stall cycle precedes every pair.
    task automatic drive_run(input bit gap);
        exp_t e;
        e.err = 5'd0;
        e.cov = 16'd0;
        e.ffv = 1'b0;
        e.ffa = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (fa[i] != gold[va[i]]) begin
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffa = va[i];
                end
                e.err = e.err + 5'd1;
            end
            e.cov = e.cov | (16'd1 << va[i]);
        end
        e.pass = (e.err == 5'd0) && (e.cov == 16'hFFFF);
        sb.push_back(e);

        for (int i = 0; i < 16; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                start    = (i == 8);
                step();
                start = 1'b0;
                check("stall_vec", 32'(vec_count), 32'(i));
                check("stall_done", 32'(done), 32'd0);
                if (i == 8) check("start_in_run_busy", 32'(busy), 32'd1);
            end
            if (i == 15) check("pre_last_done", 32'(done), 32'd0);
            in_valid = 1'b1;
            in_abcd  = va[i];
            in_f     = fa[i];
            step();
        end
        in_valid = 1'b0;

        // Verdict must be present exactly one cycle after the last accept.
        check("done_latency", 32'(done), 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("err_count", 32'(err_count), 32'(e.err));
            check("vec_count", 32'(vec_count), 32'd16);
            check("cov", 32'(cov), 32'(e.cov));
            check("pass", 32'(pass), 32'(e.pass));
            check("busy_done", 32'(busy), 32'd0);
            check("ready_done", 32'(in_ready), 32'd0);
`ifdef FCHK_FIRST_FAIL_EN
            check("ff_valid", 32'(first_fail_valid), 32'(e.ffv));
            check("ff_abcd", 32'(first_fail_abcd), 32'(e.ffa));
`endif
        end
    endtask

    task automatic load_correct();
        for (int i = 0; i < 16; i++) begin
            va[i] = 4'(i);
            fa[i] = gold[i];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_vec"}, 32'(vec_count), 32'd0);
        check({tag, "_cov"}, 32'(cov), 32'd0);
    endtask

    initial begin
        gold = 16'd0;
        foreach (minterms[k]) gold[minterms[k]] = 1'b1;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_abcd = 4'd0; in_f = 1'b0;
        step();
        step();
        check_all_zero("reset");

        // in_valid in IDLE must be ignored.
        rst = 1'b0;
        in_valid = 1'b1; in_abcd = 4'b0011; in_f = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("idle_vec", 32'(vec_count), 32'd0);
        check("idle_cov", 32'(cov), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd0);

        // Run 1: exhaustive correct pass.
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_ready", 32'(in_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        load_correct();
        drive_run(1'b0);

        // Restart from DONE with in_valid high: no accept on the restart edge.
        start = 1'b1; in_valid = 1'b1; in_abcd = 4'd5; in_f = gold[5];
        step();
        start = 1'b0; in_valid = 1'b0;
        check("restart_vec", 32'(vec_count), 32'd0);
        check("restart_cov", 32'(cov), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_pass", 32'(pass), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // Run 2: injected faults at 0000 and 1111.
        load_correct();
        fa[0]  = 1'b1;
        fa[15] = 1'b0;
        drive_run(1'b0);

        // Run 3: coverage hole, 14 repeated instead of 15.
        start = 1'b1;
        step();
        start = 1'b0;
        load_correct();
        va[15] = 4'd14;
        fa[15] = gold[14];
        drive_run(1'b0);

        // Run 4: correct pairs with in_valid toggling every other cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        load_correct();
        drive_run(1'b1);

        // Verdict holds in DONE even with in_valid asserted.
        in_valid = 1'b1; in_abcd = 4'd2; in_f = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("hold_done", 32'(done), 32'd1);
        check("hold_vec", 32'(vec_count), 32'd16);
        check("hold_pass", 32'(pass), 32'd1);

        // Reset after 7 accepts discards the run.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_abcd = 4'(i); in_f = gold[i];
            step();
        end
        check("mid_vec", 32'(vec_count), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_all_zero("midrst");

        // Run 5: full correct run after the reset; start and rst together first, rst must win.
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        load_correct();
        drive_run(1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
